bytewise_memory: RTL
====================

# bytewise_memory

Parametrised single-clock memory with one write port and one read port: byte-strobed writes, registered read with valid flag, out-of-range detection, and a hardware clear sequencer that zeroes every entry after reset or on request. It is the storage primitive behind the cache data/tag arrays and the register-file style buffers in the core. It replaces the plain word-write, combinational-read array.

## Interface
- DATA_WIDTH, 32, word width in bits; must be a multiple of 8.
- ADDR_WIDTH, 9, address width in bits.
- DEPTH, 512, number of words; 1 ≤ DEPTH ≤ 2^ADDR_WIDTH.
- CLK  in  1  clock; all state changes on the rising edge.
- RSTN  in  1  asynchronous, active-low reset.
- CLEAR  in  1  single-cycle request to re-zero the whole array.
- INIT_BUSY  out  1  high while the clear sequencer runs.
- WREN  in  1  write request.
- WADDR  in  ADDR_WIDTH  write word address.
- WSTRB  in  DATA_WIDTH/8  byte enables; bit i covers WDATA[8i+7:8i].
- WDATA  in  DATA_WIDTH  write data.
- RDEN  in  1  read request.
- RADDR  in  ADDR_WIDTH  read word address.
- RDATA  out  DATA_WIDTH  registered read data.
- RVALID  out  1  one-cycle pulse qualifying RDATA.
- ADDR_ERR  out  1  one-cycle pulse: a request in the previous cycle addressed ≥ DEPTH.

## Operation
- Two states: CLEARING and READY. A clear counter `clr_ptr` (ADDR_WIDTH bits) addresses the array while CLEARING.
- Reset (RSTN low) forces CLEARING with clr_ptr = 0. RDATA is 0, RVALID is 0, ADDR_ERR is 0, INIT_BUSY is 1. The array contents themselves are not reset asynchronously.
- CLEARING: each cycle writes all-zero to entry clr_ptr and then increments clr_ptr. In the cycle that clears entry DEPTH-1, the block moves to READY. INIT_BUSY deasserts in that transition cycle.
- While CLEARING, WREN and RDEN are ignored: there is no write, RVALID stays 0, and ADDR_ERR stays 0.
- CLEAR asserted in READY: enter CLEARING with clr_ptr = 0. A write or read issued in the same cycle is dropped.
- CLEAR asserted while CLEARING: restart the sweep from 0.
- Write in READY with WADDR < DEPTH: only the bytes with a set WSTRB bit are updated. WSTRB = 0 is a legal no-op.
- Write in READY with WADDR ≥ DEPTH: the array is unchanged and ADDR_ERR pulses.
- Read in READY with RADDR < DEPTH: RDATA = mem[RADDR] and RVALID = 1 on the next edge.
- Read in READY with RADDR ≥ DEPTH: RDATA = 0, RVALID = 1, and ADDR_ERR = 1 on the next edge.
- RDATA holds its last value when RVALID = 0.
- Simultaneous read and write to different addresses: the two are independent.
- Simultaneous read and write to the same address: the result depends on the Configuration section.

## Timing
- Read latency: exactly 1 cycle from RDEN sampled high to RVALID/RDATA.
- Full throughput: one read and one write accepted every cycle in READY.
- A written value is visible to a read issued on the following cycle.
- Clear duration: DEPTH cycles after RSTN rises, or after the CLEAR edge. The first accepted request is on cycle DEPTH.
- ADDR_ERR is registered: it pulses in the same cycle RVALID would pulse for that request. For writes it pulses 1 cycle after WREN.
- If RSTN is asserted mid-operation, all outputs immediately take their reset values. An in-flight read is lost.

## Configuration
- MEMORY_BYPASS_EN defined: a same-cycle read and write to the same in-range address returns the merged word on RDATA. Strobed bytes come from WDATA; the other bytes come from the old contents.
- MEMORY_BYPASS_EN undefined: the same case returns the old word (read-before-write). The new data is visible from the next read onward.
- In both builds, the array ends up holding the merged word.

## Test plan
- Reset with DEPTH = 16, hold RSTN low 3 cycles, then release -> INIT_BUSY high for 16 cycles. After that, reading every address returns 0 with RVALID one cycle after RDEN.
- Write 0xDEADBEEF to addr 5 with WSTRB = 0xF, then write 0x000000AA with WSTRB = 0x1, then read addr 5 -> RDATA = 0xDEADBEAA.
- Same-cycle write 0x12345678 (WSTRB = 0xF) and read at addr 3, which holds 0 -> RDATA = 0x12345678 with MEMORY_BYPASS_EN, 0x00000000 without. A following read returns 0x12345678 in both builds.
- Read addr 20 with DEPTH = 16 -> RVALID = 1, RDATA = 0, ADDR_ERR = 1. A write to addr 20 -> ADDR_ERR pulses and no entry changes.
- Assert CLEAR after populating memory, and issue WREN in the same cycle -> the write is dropped and INIT_BUSY is high for 16 cycles. RDEN during the sweep gives no RVALID. All entries read 0 afterwards.
- Pull RSTN low at clr_ptr = 7 -> outputs are reset. After release, the sweep restarts and takes the full 16 cycles.

Source files
------------

// File: rtl/bytewise_memory.sv
`default_nettype none
// ============================================================================
// Module      : bytewise_memory
// Description : Single-clock memory with one write port and one read port.
//               Byte-strobed writes, registered read with valid flag,
//               out-of-range detection and a clear sequencer that zeroes
//               every entry after reset or on request.
//               Optional build macro: MEMORY_BYPASS_EN -- a same-cycle read
//               and write to the same in-range address returns the merged
//               word; otherwise the read returns the old word.
// Ports       : clk        - clock, rising edge
//               rst_n      - asynchronous active-low reset
//               clear      - one-cycle request to re-zero the array
//               init_busy  - high while the clear sweep runs
//               wren/waddr/wstrb/wdata - write port (byte strobes)
//               rden/raddr - read request
//               rdata/rvalid - registered read data and its qualifier
//               addr_err   - pulse: a request in the previous cycle was >= DEPTH
// Revision    : 1.0 - initial release
// ============================================================================
module bytewise_memory #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 9,
    parameter int DEPTH      = 512
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear,
    output logic                    init_busy,
    input  logic                    wren,
    input  logic [ADDR_WIDTH-1:0]   waddr,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic                    rden,
    input  logic [ADDR_WIDTH-1:0]   raddr,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic                    rvalid,
    output logic                    addr_err
);

    localparam int                    NUM_BYTES = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
    // One extra bit so DEPTH == 2**ADDR_WIDTH is representable.
    localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);

    typedef enum logic [0:0] {
        S_CLEARING = 1'b0,
        S_READY    = 1'b1
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [ADDR_WIDTH-1:0]   clr_ptr;
    logic [ADDR_WIDTH-1:0]   clr_ptr_next;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic                    accept;
    logic                    wr_req;
    logic                    rd_req;
    logic                    wr_in_range;
    logic                    rd_in_range;
    logic [DATA_WIDTH-1:0]   wr_old;
    logic [DATA_WIDTH-1:0]   wr_merged;

    // Requests are only honoured in READY; a CLEAR in the same cycle wins.
    assign accept      = (state == S_READY) && !clear;
    assign wr_req      = accept && wren;
    assign rd_req      = accept && rden;
    assign wr_in_range = ({1'b0, waddr} < DEPTH_EXT);
    assign rd_in_range = ({1'b0, raddr} < DEPTH_EXT);
    assign init_busy   = (state == S_CLEARING);

    // Read-modify-write merge of the strobed bytes into the current word.
    assign wr_old = wr_in_range ? mem[waddr] : '0;

    always_comb begin
        wr_merged = wr_old;
        for (int b = 0; b < NUM_BYTES; b++) begin
            if (wstrb[b]) begin
                wr_merged[8*b +: 8] = wdata[8*b +: 8];
            end
        end
    end

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_CLEARING;
            clr_ptr <= '0;
        end else begin
            state   <= state_next;
            clr_ptr <= clr_ptr_next;
        end
    end

    always_comb begin
        state_next   = state;
        clr_ptr_next = clr_ptr;
        case (state)
            S_CLEARING: begin
                if (clear) begin
                    clr_ptr_next = '0;
                end else if (clr_ptr == LAST_ADDR) begin
                    state_next   = S_READY;
                    clr_ptr_next = '0;
                end else begin
                    clr_ptr_next = clr_ptr + 1'b1;
                end
            end
            S_READY: begin
                if (clear) begin
                    state_next   = S_CLEARING;
                    clr_ptr_next = '0;
                end
            end
            default: begin
                state_next   = S_CLEARING;
                clr_ptr_next = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Storage array (no reset; the sweep provides the initial zeroes)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (state == S_CLEARING) begin
            mem[clr_ptr] <= '0;
        end else if (wr_req && wr_in_range) begin
            mem[waddr] <= wr_merged;
        end
    end

    // ------------------------------------------------------------------
    // Registered read port and error flag
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata    <= '0;
            rvalid   <= 1'b0;
            addr_err <= 1'b0;
        end else begin
            rvalid   <= rd_req;
            addr_err <= (rd_req && !rd_in_range) || (wr_req && !wr_in_range);
            if (rd_req) begin
                if (!rd_in_range) begin
                    rdata <= '0;
`ifdef MEMORY_BYPASS_EN
                end else if (wr_req && wr_in_range && (waddr == raddr)) begin
                    rdata <= wr_merged;
`endif
                end else begin
                    // Non-blocking array update means this is the old word.
                    rdata <= mem[raddr];
                end
            end
        end
    end

endmodule
`default_nettype wire
